// File: rtl/alif_param_loader.sv
// ALIF parameter loader: receives a byte-serial frame into shadow registers and commits it atomically.
// Define LOADER_CHECKSUM_EN for a 5-byte frame whose last byte is the XOR of the first four.
module alif_param_loader #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [2:0] weight_a,
    output logic [2:0] weight_b,
    output logic [7:0] leak_rate,
    output logic [7:0] threshold_min,
    output logic [3:0] leak_cycles,
    output logic       params_ready,
    output logic       load_error
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    typedef enum logic [1:0] {IDLE, RECV} state_t;
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    state_t     state_q;
    logic [2:0] idx_q;
    logic [7:0] to_cnt_q;
    logic       data_ready_q;
    logic       load_error_q;
    logic       params_ready_q;
    logic [2:0] wa_q, wb_q;
    logic [7:0] lr_q, tm_q;
    logic [3:0] lc_q;
    logic [2:0] sh_wa_q, sh_wb_q;
    logic [7:0] sh_lr_q, sh_tm_q;
`ifdef LOADER_CHECKSUM_EN
    logic [3:0] sh_lc_q;
    logic [7:0] xor_q;
`endif

    logic       accept;
    logic [2:0] byte_idx_d;
    logic [7:0] to_cnt_d;

    // A restart request that coincides with a handshake turns that byte into B0.
    assign accept     = data_ready_q & data_valid;
    assign byte_idx_d = load_start ? 3'd0 : idx_q;
    assign to_cnt_d   = to_cnt_q + 8'd1;

    // NOTE: shadows carry an async reset too, so the post-reset state is fully defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_wa_q <= '0;
            sh_wb_q <= '0;
            sh_lr_q <= '0;
            sh_tm_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sh_lc_q <= '0;
`endif
        end else if (accept) begin
            case (byte_idx_d)
                3'd0: begin
                    sh_wa_q <= data_in[7:5];
                    sh_wb_q <= data_in[4:2];
                end
                3'd1: sh_lr_q <= data_in;
                3'd2: sh_tm_q <= data_in;
`ifdef LOADER_CHECKSUM_EN
                3'd3: sh_lc_q <= data_in[7:4];
`endif
                default: ;
            endcase
        end
    end

    // NOTE: all FSM state and outputs use non-blocking assignments so every field commits on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            to_cnt_q       <= '0;
            data_ready_q   <= 1'b0;
            load_error_q   <= 1'b0;
            params_ready_q <= 1'b0;
            wa_q           <= '0;
            wb_q           <= '0;
            lr_q           <= '0;
            tm_q           <= '0;
            lc_q           <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q          <= '0;
`endif
        end else begin
            load_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_q      <= RECV;
                        data_ready_q <= 1'b1;
                        idx_q        <= '0;
                        to_cnt_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        xor_q        <= '0;
`endif
                    end
                end
                RECV: begin
                    if (accept) begin
                        idx_q    <= byte_idx_d + 3'd1;
                        to_cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                        xor_q    <= (load_start ? 8'd0 : xor_q) ^ data_in;
                        if (byte_idx_d == LAST_IDX) begin
                            state_q      <= CHECK;
                            data_ready_q <= 1'b0;
                        end
`else
                        if (byte_idx_d == LAST_IDX) begin
                            wa_q           <= sh_wa_q;
                            wb_q           <= sh_wb_q;
                            lr_q           <= sh_lr_q;
                            tm_q           <= sh_tm_q;
                            lc_q           <= data_in[7:4];
                            params_ready_q <= 1'b1;
                            state_q        <= IDLE;
                            data_ready_q   <= 1'b0;
                        end
`endif
                    end else if (load_start) begin
                        idx_q    <= '0;
                        to_cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                        xor_q    <= '0;
`endif
                    end else if (to_cnt_d == TIMEOUT_CYCLES) begin
                        load_error_q <= 1'b1;
                        state_q      <= IDLE;
                        data_ready_q <= 1'b0;
                        to_cnt_q     <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    // XOR over all five bytes is zero exactly when the checksum matches.
                    if (xor_q == 8'd0) begin
                        wa_q           <= sh_wa_q;
                        wb_q           <= sh_wb_q;
                        lr_q           <= sh_lr_q;
                        tm_q           <= sh_tm_q;
                        lc_q           <= sh_lc_q;
                        params_ready_q <= 1'b1;
                    end else begin
                        load_error_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
`endif
                default: begin
                    state_q      <= IDLE;
                    data_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign data_ready    = data_ready_q;
    assign load_error    = load_error_q;
    assign params_ready  = params_ready_q;
    assign weight_a      = wa_q;
    assign weight_b      = wb_q;
    assign leak_rate     = lr_q;
    assign threshold_min = tm_q;
    assign leak_cycles   = lc_q;

endmodule

// File: tb/tb_alif_param_loader.sv
// Scoreboard bench for alif_param_loader: drivers push expected commit/error events,
// a monitor pops them whenever the loader commits or flags an error.
module tb_alif_param_loader;

    localparam logic [7:0] TO = 8'd200;
`ifdef LOADER_CHECKSUM_EN
    localparam int FLEN    = 5;
    localparam bit CSUM_EN = 1'b1;
`else
    localparam int FLEN    = 4;
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct packed {
        logic       err;
        logic [2:0] wa;
        logic [2:0] wb;
        logic [7:0] lr;
        logic [7:0] tm;
        logic [3:0] lc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready, params_ready, load_error;
    logic [2:0] weight_a, weight_b;
    logic [7:0] leak_rate, threshold_min;
    logic [3:0] leak_cycles;
    logic [25:0] out_params;

    exp_t        exp_q[$];
    logic [25:0] model_params = '0;
    logic        model_ready = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    alif_param_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready), .weight_a(weight_a),
        .weight_b(weight_b), .leak_rate(leak_rate), .threshold_min(threshold_min),
        .leak_cycles(leak_cycles), .params_ready(params_ready), .load_error(load_error)
    );

    assign out_params = {weight_a, weight_b, leak_rate, threshold_min, leak_cycles};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode: field placement within the four payload bytes.
    function automatic exp_t decode(input logic [31:0] f);
        exp_t e;
        e.err = 1'b0;
        e.wa  = f[31:29];
        e.wb  = f[28:26];
        e.lr  = f[23:16];
        e.tm  = f[15:8];
        e.lc  = f[7:4];
        return e;
    endfunction

    // A frame whose decoded fields differ from the current ones, so its commit is observable.
    function automatic logic [31:0] fresh();
        logic [31:0] f;
        exp_t d;
        f = $urandom;
        d = decode(f);
        while (model_ready && d[25:0] == model_params) begin
            f = $urandom;
            d = decode(f);
        end
        return f;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        sync();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        int waited;
        waited = 0;
        repeat (gap) sync();
        data_in    = b;
        data_valid = 1'b1;
        load_start = with_start;
        forever begin
            @(negedge clk);
            if (data_ready === 1'b1) break;
            waited++;
            if (waited > 20) begin
                check("handshake wait", 32'd0, 32'd1);
                break;
            end
        end
        sync();
        data_valid = 1'b0;
        load_start = 1'b0;
    endtask

    // mask != 0 corrupts the checksum byte (checksum build only).
    task automatic send_frame(input logic [31:0] f, input int gap, input logic [7:0] mask,
                              input bit restart_b0);
        exp_t e;
        logic [7:0] cs;
        cs = f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
        e = decode(f);
        e.err = CSUM_EN && (mask != 8'd0);
        exp_q.push_back(e);
        if (!e.err) begin
            model_params = e[25:0];
            model_ready  = 1'b1;
        end
        if (!restart_b0) pulse_start();
        for (int i = 0; i < 4; i++) send_byte(f[31-8*i -: 8], gap, restart_b0 && i == 0);
        if (CSUM_EN) send_byte(cs ^ mask, gap, 1'b0);
    endtask

    task automatic wait_timeout(input string name);
        exp_t e;
        int cnt;
        e = '0;
        e.err = 1'b1;
        exp_q.push_back(e);
        cnt = 0;
        while (cnt < 400) begin
            @(negedge clk);
            cnt++;
            if (load_error === 1'b1) break;
        end
        check(name, cnt, 32'(TO) + 32'd1);
        @(negedge clk);
        check("error pulse one cycle", {31'd0, load_error}, 32'd0);
        check("idle after timeout", {31'd0, data_ready}, 32'd0);
        sync();
    endtask

    task automatic wait_commit_latency(input string name);
        @(negedge clk);
        if (CSUM_EN) @(negedge clk);
        check(name, {31'd0, params_ready}, 32'd1);
        sync();
    endtask

    initial begin : monitor
        logic [26:0] prev;
        logic [26:0] cur;
        exp_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {params_ready, out_params};
            if (!rst_n) begin
                prev = cur;
                continue;
            end
            if (load_error === 1'b1) begin
                if (exp_q.size() == 0) check("unexpected load_error", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("event is error", {31'd0, e.err}, 32'd1);
                end
            end
            if (cur !== prev) begin
                if (exp_q.size() == 0) check("unexpected output change", {5'd0, cur}, {5'd0, prev});
                else begin
                    e = exp_q.pop_front();
                    check("event is commit", {31'd0, e.err}, 32'd0);
                    check("committed params", {5'd0, cur}, {5'd0, 1'b1, e[25:0]});
                end
            end
            prev = cur;
        end
    end

    initial begin : stimulus
        logic [31:0] f;
        logic [31:0] junk;
        int kind, gap, k;

        repeat (3) sync();
        check("reset outputs", {3'd0, data_ready, load_error, params_ready, out_params}, 32'd0);
        rst_n = 1'b1;
        sync();

        send_frame(32'h6C052030, 0, 8'h00, 1'b0);
        wait_commit_latency("params_ready latency frame1");
        check("frame1 values", {6'd0, out_params}, {6'd0, 3'd3, 3'd3, 8'd5, 8'd32, 4'd3});

        send_frame(32'hE0021080, 10, 8'h00, 1'b0);
        wait_commit_latency("params_ready latency frame2");
        check("frame2 values", {6'd0, out_params}, {6'd0, 3'd7, 3'd0, 8'd2, 8'd16, 4'd8});

        pulse_start();
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        wait_timeout("timeout latency");
        check("params kept after timeout", {5'd0, params_ready, out_params},
              {5'd0, 1'b1, 3'd7, 3'd0, 8'd2, 8'd16, 4'd8});

        if (CSUM_EN) begin
            send_frame(32'h6C052030, 0, 8'h79, 1'b0);
            @(negedge clk);
            check("check state not ready", {31'd0, data_ready}, 32'd0);
            check("no error during check", {31'd0, load_error}, 32'd0);
            @(negedge clk);
            check("checksum error pulse", {31'd0, load_error}, 32'd1);
            check("params kept after bad sum", {6'd0, out_params},
                  {6'd0, 3'd7, 3'd0, 8'd2, 8'd16, 4'd8});
            sync();
            sync();
        end

        f = fresh();
        pulse_start();
        send_byte(f[31:24], 0, 1'b0);
        send_byte(f[23:16], 0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("async reset outputs", {3'd0, data_ready, load_error, params_ready, out_params}, 32'd0);
        model_ready  = 1'b0;
        model_params = '0;
        sync();
        sync();
        rst_n = 1'b1;
        sync();
        f = fresh();
        send_frame(f, 1, 8'h00, 1'b0);
        wait_commit_latency("commit after reset");
        check("values after reset", {6'd0, out_params}, {6'd0, model_params});

        junk = $urandom;
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(junk[31-8*i -: 8], 0, 1'b0);
        f = fresh();
        send_frame(f, 0, 8'h00, 1'b0);
        wait_commit_latency("commit after restart");
        check("values after restart", {6'd0, out_params}, {6'd0, decode(f)[25:0]});

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            gap  = $urandom_range(0, 3);
            f    = fresh();
            if (kind < 5) begin
                send_frame(f, gap, 8'h00, 1'b0);
            end else if (kind < 8) begin
                junk = $urandom;
                k = $urandom_range(1, FLEN - 1);
                pulse_start();
                for (int i = 0; i < k; i++) send_byte(junk[31-8*i -: 8], gap, 1'b0);
                send_frame(f, gap, 8'h00, 1'($urandom_range(0, 1)));
            end else if (kind == 8) begin
                send_frame(f, gap, CSUM_EN ? 8'($urandom_range(1, 255)) : 8'h00, 1'b0);
            end else begin
                junk = $urandom;
                k = $urandom_range(0, FLEN - 1);
                pulse_start();
                for (int i = 0; i < k; i++) send_byte(junk[31-8*i -: 8], gap, 1'b0);
                wait_timeout("random timeout latency");
            end
            sync();
            sync();
        end

        repeat (5) sync();
        check("scoreboard drained", exp_q.size(), 32'd0);
        check("final params", {5'd0, params_ready, out_params}, {5'd0, model_ready, model_params});
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alif_param_loader.md
ALIF_PARAM_LOADER -- requirements
Module: alif_param_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8'd200, max idle cycles between accepted bytes during a frame.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port load_start  input  1  one-cycle request to begin a new parameter frame.
REQ-005 SHALL have port data_in  input  8  frame byte.
REQ-006 SHALL have port data_valid  input  1  data_in valid.
REQ-007 SHALL have port data_ready  output  1  loader can accept a byte.
REQ-008 SHALL have ports weight_a / weight_b  output  3 each  committed synaptic weights.
REQ-009 SHALL have ports leak_rate / threshold_min  output  8 each  committed leak amount / base threshold.
REQ-010 SHALL have port leak_cycles  output  4  committed cycles between leaks.
REQ-011 SHALL have port params_ready  output  1  a valid parameter set has been committed.
REQ-012 SHALL have port load_error  output  1  one-cycle pulse on aborted/rejected frame.

Function
REQ-013 SHALL implement states IDLE, RECV, CHECK (CHECK only with checksum feature).
REQ-014 IDLE: data_ready=0; load_start=1 -> RECV, byte index=0, timeout counter=0.
REQ-015 RECV: data_ready=1; byte accepted iff data_valid && data_ready on a clock edge; index increments per accepted byte.
REQ-016 Frame byte order: B0={weight_a[7:5], weight_b[4:2], reserved[1:0]}, B1=leak_rate, B2=threshold_min, B3={leak_cycles[7:4], reserved[3:0]}; reserved bits ignored.
REQ-017 Accepted bytes SHALL go to shadow registers only; outputs unchanged until commit.
REQ-018 Commit SHALL copy all shadow fields to outputs on the same edge (atomic), set params_ready=1, return to IDLE.
REQ-019 params_ready SHALL stay 1 after first commit through later loads, errors and aborts; only reset clears it.
REQ-020 Timeout counter SHALL reset on every accepted byte and increment each RECV cycle otherwise; reaching TIMEOUT_CYCLES -> pulse load_error, IDLE, shadows discarded, outputs unchanged.
REQ-021 load_start asserted in RECV SHALL restart the frame (index=0, timeout=0), no error pulse; if a byte is accepted the same cycle it SHALL be taken as B0.
REQ-022 load_start in IDLE the cycle a commit returns to IDLE is not possible; load_start during CHECK SHALL be ignored.
REQ-023 load_error SHALL be 1 for exactly one cycle per error event.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, index=0, timeout=0, data_ready=0, all parameter outputs 0, params_ready=0, load_error=0, shadows 0.
REQ-025 Reset mid-frame SHALL discard the partial frame; after release, loader SHALL wait in IDLE for load_start.

Configuration
REQ-026 Macro LOADER_CHECKSUM_EN defined: frame is 5 bytes, B4 = XOR of B0..B3; after B4 accepted -> CHECK (data_ready=0) for one cycle; match -> commit; mismatch -> pulse load_error, IDLE, outputs unchanged.
REQ-027 Macro LOADER_CHECKSUM_EN undefined: frame is 4 bytes; commit on the edge after B3 is accepted (params_ready visible the cycle after B3 handshake); no CHECK state.

Verification
REQ-028 Reset then load_start, bytes 0x6C,0x05,0x20,0x30 (+0x79 if checksum) -> weight_a=3, weight_b=3, leak_rate=5, threshold_min=32, leak_cycles=3, params_ready=1, load_error never 1.
REQ-029 After REQ-028, data_valid gaps of 10 cycles between bytes of frame 0xE0,0x02,0x10,0x80(+0x72) -> outputs unchanged until commit, then weight_a=7, weight_b=0, leak_rate=2, threshold_min=16, leak_cycles=8.
REQ-030 Send 2 bytes then stall TIMEOUT_CYCLES cycles -> single load_error pulse, state IDLE, previous parameters and params_ready=1 retained.
REQ-031 With LOADER_CHECKSUM_EN: frame 0x6C,0x05,0x20,0x30,0x00 -> load_error pulse one cycle after B4, outputs unchanged.
REQ-032 Assert rst_n=0 asynchronously mid-frame after B1 -> all outputs 0 before next clock edge; new full frame after release commits correctly.
REQ-033 load_start reissued after B2 -> no error, next four (five) bytes form the committed frame.
